// File: rtl/rc5_pkg.sv
// rc5_pkg: shared widths, arbiter state encoding and operand bundle for the RC5 core
package rc5_pkg;
  localparam int RC5_BLOCK_W = 64;
  localparam int RC5_KEY_W = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} arb_state_t;
  typedef struct packed {
    logic decrypt;
    logic [RC5_BLOCK_W-1:0] data;
    logic [RC5_KEY_W-1:0] key;
  } rc5_op_t;
endpackage

// File: rtl/rc5_core_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, first request at or after ptr
module rr_grant #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // scan from farthest to nearest so the request closest to ptr is written last
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
  end
  assign any = |req;
  assign grant = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/rc5_core_arbiter.sv
// rc5_core_arbiter: shares one RC5 core between NUM_REQ requesters with round-robin grant and watchdog
module rc5_core_arbiter
  import rc5_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_decrypt,
  input  logic [NUM_REQ*RC5_BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ*RC5_KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [RC5_BLOCK_W-1:0]       rsp_data,
  output logic                         rsp_error,
  output logic                         core_start,
  output logic                         core_decrypt,
  output logic [RC5_BLOCK_W-1:0]       core_data_in,
  output logic [RC5_KEY_W-1:0]         core_key,
  input  logic [RC5_BLOCK_W-1:0]       core_data_out,
  input  logic                         core_done,
  output logic                         busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t state;
  rc5_op_t op;
  logic [IW-1:0] rr_ptr, owner, g_idx;
  logic [NUM_REQ-1:0] g_oh;
  logic g_any, done_q, fire;
  logic [CNT_W-1:0] wd;
  rr_grant #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(g_oh),
    .idx(g_idx),
    .any(g_any)
  );
  assign fire = core_done & ~done_q;
  assign req_ready = (state == IDLE) ? g_oh : '0;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign core_start = state == ISSUE;
  assign busy = state != IDLE;
  assign core_decrypt = op.decrypt;
  assign core_data_in = op.data;
  assign core_key = op.key;
  // arbitration FSM: grant and latch, pulse start, wait for a done edge or watchdog, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op <= '0;
      done_q <= 1'b0;
      wd <= '0;
      rsp_data <= '0;
      rsp_error <= 1'b0;
    end else begin
      done_q <= core_done;
      case (state)
        IDLE: if (g_any) begin
          op <= '{decrypt: req_decrypt[g_idx],
                  data: req_data[int'(g_idx)*RC5_BLOCK_W +: RC5_BLOCK_W],
                  key: req_key[int'(g_idx)*RC5_KEY_W +: RC5_KEY_W]};
          owner <= g_idx;
          rr_ptr <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          wd <= '0;
          state <= WAIT;
        end
        WAIT: if (fire) begin
          rsp_data <= core_data_out;
          rsp_error <= 1'b0;
          state <= RESP;
        end else if (wd == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data <= '0;
          rsp_error <= 1'b1;
          state <= RESP;
        end else wd <= wd + 1'b1;
        RESP: if (rsp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rc5_core_arbiter.md
Name: rc5_core_arbiter

Overview:
Shares one RC5 encrypt/decrypt core (start/done, 64-bit block, 128-bit key) between NUM_REQ requesters with valid/ready handshakes. Round-robin grant, operand latching and start-pulse generation. Completion detection on the core's done signal, response return and a watchdog timeout. Sits between the bus-side clients and the RC5 toplevel.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before an error response is returned
CNT_W, 11, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_decrypt  in  NUM_REQ  0 = encrypt, 1 = decrypt
req_data  in  NUM_REQ*64  block per requester; slice i = [i*64 +: 64]
req_key  in  NUM_REQ*128  key per requester; slice i = [i*128 +: 128]
rsp_valid  out  NUM_REQ  response valid to the owning requester; one-hot or zero
rsp_ready  in  NUM_REQ  response accept
rsp_data  out  64  result block (shared)
rsp_error  out  1  1 = watchdog timeout; rsp_data is 0
core_start  out  1  single-cycle start pulse to the RC5 core
core_decrypt  out  1  mode to the core
core_data_in  out  64  block to the core
core_key  out  128  key to the core
core_data_out  in  64  core result
core_done  in  1  core completion level; may stay high between operations
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, rr_ptr 0. req_ready, rsp_valid, core_start, rsp_error, busy = 0. core_data_in, core_key, rsp_data = 0. core_decrypt 0. done_q 0. Watchdog count 0.
- Reset mid-operation abandons the transaction: no response is issued and the core is not cancelled. Done edges arriving after reset are ignored because the state is IDLE.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req_valid is high, grant g = first requester at or after rr_ptr, modulo NUM_REQ. req_ready[g] = 1 combinationally in this cycle. The handshake completes this cycle: latch req_data, req_key, req_decrypt slices of g plus the owner id g. Next state ISSUE. rr_ptr <= (g+1) mod NUM_REQ.
- ISSUE: core_start = 1 for exactly one cycle. Operand registers stay stable from ISSUE until leaving RESP. Clear the watchdog. Next state WAIT.
- WAIT: completion = core_done & ~done_q, where done_q is core_done registered every cycle. A sticky done from a prior operation is therefore not taken as completion.
  - On completion: latch rsp_data <= core_data_out, rsp_error <= 0, go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES-1 without completion: rsp_data <= 0, rsp_error <= 1, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: rsp_valid[owner] = 1. rsp_data and rsp_error are held until rsp_ready[owner] is high, then go to IDLE. rsp_ready of non-owners is ignored.
- Single outstanding transaction. req_ready is 0 in all states except IDLE. A requester may hold req_valid during its own RESP; it is arbitrated in the next IDLE.
- Latency with an ideal core (done edge L cycles after start) and rsp_ready held high: accept in cycle 0, core_start in cycle 1, response valid in cycle 2+L, next accept in cycle 3+L.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- rsp_data and rsp_error are defined only while some rsp_valid bit is high.

Decomposition:
- Shared package rc5_pkg:
  - RC5_BLOCK_W = 64 and RC5_KEY_W = 128.
  - Typedef for the arbiter state enum (IDLE, ISSUE, WAIT, RESP).
  - Packed struct rc5_op_t {decrypt, data, key}.
- One sub-module, rr_grant: a combinational round-robin picker taking a request vector and pointer and returning a one-hot grant plus index. It is reused by other shared-resource controllers.

Test Plan:
- Reset during WAIT (assert rst 1 cycle, then done edge) -> all outputs at reset values, no rsp_valid, next grant goes to requester 0.
- Single encrypt: requester 0, data 0123456789ABCDEF, key 00112233445566778899AABBCCDDEEFF, core model L = 12 -> one core_start pulse in cycle 1; rsp_valid[0] in cycle 14 with rsp_data = the core output; rsp_error 0.
- Round trip: feed the encrypted result back from requester 1 with decrypt = 1 -> rsp_data = 0123456789ABCDEF on rsp_valid[1].
- Contention: both requesters valid continuously for 4 transactions -> grant order 0,1,0,1. core_start is never asserted while busy with an earlier operation.
- Sticky done: core_done held high from the previous op through the next ISSUE, falling in WAIT cycle 3 and rising in cycle 9 -> completion taken only in cycle 9.
- Timeout: core never asserts done, TIMEOUT_CYCLES = 16 -> rsp_valid 16 cycles after entering WAIT, with rsp_error 1 and rsp_data 0.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_data and rsp_error stable throughout; req_ready stays 0 until 1 cycle after rsp_ready.
